// File: rtl/rvfpm_pkg.sv
// Shared types and helpers for the rvfpm issue controller.
// X_ID_WIDTH here sets the ID field width of a queue entry; the controller's
// X_ID_WIDTH parameter defaults to it and must be kept equal to it.
package rvfpm_pkg;

    localparam int X_ID_WIDTH = 4;

    // One buffered offload: the instruction plus its commit/kill state.
    typedef struct packed {
        logic [31:0]           instr;
        logic [X_ID_WIDTH-1:0] id;
        logic                  committed;
        logic                  killed;
    } issue_entry_t;

    // Pointer width for a power-of-two circular buffer; pointers wrap naturally.
    function automatic int qptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/rvfpm_id_match.sv
// Parallel ID comparator: flags every valid queue slot whose ID equals id.
// Slot order is physical (not relative to the queue head).
module rvfpm_id_match #(
    parameter int X_ID_WIDTH  = 4,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic [QUEUE_DEPTH*X_ID_WIDTH-1:0] ids,
    input  logic [QUEUE_DEPTH-1:0]            valid,
    input  logic [X_ID_WIDTH-1:0]             id,
    output logic [QUEUE_DEPTH-1:0]            match
);
    import rvfpm_pkg::*;

    genvar gi;
    generate
        for (gi = 0; gi < QUEUE_DEPTH; gi++) begin : g_cmp
            assign match[gi] = valid[gi] && (ids[gi*X_ID_WIDTH +: X_ID_WIDTH] == id);
        end
    endgenerate

endmodule

// File: rtl/rvfpm_issue_ctrl.sv
// In-order issue buffer between the CORE-V-XIF offload port and the rvfpm
// pipeline. Entries wait for commit/kill by ID; committed heads are dispatched
// one per cycle, killed heads are dropped silently.
// Optional feature: define RVFPM_DUP_ID_CHECK_EN to refuse an issue whose ID
// already sits in a live (valid, non-killed) entry.
module rvfpm_issue_ctrl #(
    parameter int X_ID_WIDTH  = rvfpm_pkg::X_ID_WIDTH,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                                ck,
    input  logic                                rst,
    input  logic                                enable,
    input  logic                                issue_valid,
    output logic                                issue_ready,
    input  logic [31:0]                         issue_instr,
    input  logic [X_ID_WIDTH-1:0]               issue_id,
    input  logic                                commit_valid,
    input  logic [X_ID_WIDTH-1:0]               commit_id,
    input  logic                                commit_kill,
    output logic                                fpu_valid,
    input  logic                                fpu_ready,
    output logic [31:0]                         fpu_instr,
    output logic [X_ID_WIDTH-1:0]               fpu_id,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]    queue_count,
    output logic [QUEUE_DEPTH*X_ID_WIDTH-1:0]   queue_ids,
    output logic [QUEUE_DEPTH-1:0]              queue_valid
);
    import rvfpm_pkg::*;

    localparam int PTR_W = qptr_width(QUEUE_DEPTH);
    localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

    issue_entry_t                    entry_reg [QUEUE_DEPTH];
    logic [QUEUE_DEPTH-1:0]          valid_reg;
    logic [PTR_W-1:0]                head_reg;
    logic [PTR_W-1:0]                tail_reg;
    logic [CNT_W-1:0]                count_reg;
    logic [CNT_W-1:0]                count_next;

    logic [QUEUE_DEPTH*X_ID_WIDTH-1:0] id_flat;
    logic [QUEUE_DEPTH-1:0]          commit_match;
    issue_entry_t                    head_entry;
    logic                            head_valid;
    logic                            push;
    logic                            pop;
    logic                            dup_hit;
    logic                            issue_commit_hit;

    genvar gi;

    // Flattened IDs for the comparators, and the head-relative export view.
    generate
        for (gi = 0; gi < QUEUE_DEPTH; gi++) begin : g_slot
            logic [PTR_W-1:0] slot_idx;
            assign id_flat[gi*X_ID_WIDTH +: X_ID_WIDTH] = entry_reg[gi].id;
            assign slot_idx = head_reg + PTR_W'(gi);
            assign queue_valid[gi] = valid_reg[slot_idx];
            assign queue_ids[gi*X_ID_WIDTH +: X_ID_WIDTH] =
                valid_reg[slot_idx] ? entry_reg[slot_idx].id : '0;
        end
    endgenerate

    rvfpm_id_match #(
        .X_ID_WIDTH  (X_ID_WIDTH),
        .QUEUE_DEPTH (QUEUE_DEPTH)
    ) u_commit_match (
        .ids   (id_flat),
        .valid (valid_reg),
        .id    (commit_id),
        .match (commit_match)
    );

`ifdef RVFPM_DUP_ID_CHECK_EN
    logic [QUEUE_DEPTH-1:0] live_vec;
    logic [QUEUE_DEPTH-1:0] issue_match;

    // Killed entries are on their way out, so they do not block reuse of the ID.
    generate
        for (gi = 0; gi < QUEUE_DEPTH; gi++) begin : g_live
            assign live_vec[gi] = valid_reg[gi] && !entry_reg[gi].killed;
        end
    endgenerate

    rvfpm_id_match #(
        .X_ID_WIDTH  (X_ID_WIDTH),
        .QUEUE_DEPTH (QUEUE_DEPTH)
    ) u_issue_match (
        .ids   (id_flat),
        .valid (live_vec),
        .id    (issue_id),
        .match (issue_match)
    );

    assign dup_hit = |issue_match;
`else
    assign dup_hit = 1'b0;
`endif

    assign head_entry       = entry_reg[head_reg];
    assign head_valid       = valid_reg[head_reg];
    assign issue_commit_hit = commit_valid && (commit_id == issue_id);
    assign queue_count      = count_reg;

    // Handshake decode; acceptance uses registered occupancy only (no pop credit).
    always_comb begin
        issue_ready = 1'b0;
        fpu_valid   = 1'b0;
        fpu_instr   = '0;
        fpu_id      = '0;
        if (!rst) begin
            issue_ready = enable && (count_reg < CNT_W'(QUEUE_DEPTH)) && !dup_hit;
            fpu_valid   = enable && head_valid && head_entry.committed && !head_entry.killed;
        end
        if (head_valid) begin
            fpu_instr = head_entry.instr;
            fpu_id    = head_entry.id;
        end
        push       = issue_valid && issue_ready;
        // A killed head drains regardless of enable; only one pop per cycle.
        pop        = (head_valid && head_entry.killed) || (fpu_valid && fpu_ready);
        count_next = count_reg + CNT_W'(push) - CNT_W'(pop);
    end

    // Queue state: flag updates from commit/kill, push at tail, pop at head.
    always_ff @(posedge ck) begin
        if (rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
            valid_reg <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                entry_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                if (commit_valid && commit_match[i]) begin
                    if (commit_kill) begin
                        entry_reg[i].killed <= 1'b1;
                    end else begin
                        entry_reg[i].committed <= 1'b1;
                    end
                end
            end
            // The tail slot is never valid when pushing, so it cannot collide
            // with the flag updates above; a same-cycle commit lands directly.
            if (push) begin
                entry_reg[tail_reg].instr     <= issue_instr;
                entry_reg[tail_reg].id        <= issue_id;
                entry_reg[tail_reg].committed <= issue_commit_hit && !commit_kill;
                entry_reg[tail_reg].killed    <= issue_commit_hit && commit_kill;
                valid_reg[tail_reg]           <= 1'b1;
                tail_reg                      <= tail_reg + 1'b1;
            end
            if (pop) begin
                valid_reg[head_reg] <= 1'b0;
                head_reg            <= head_reg + 1'b1;
            end
            count_reg <= count_next;
        end
    end

endmodule

// File: tb/tb_rvfpm_issue_ctrl.sv
// Self-checking bench for rvfpm_issue_ctrl: a vector table for the main flow
// plus hand-written sequences for reset, kill, backpressure and duplicate IDs.
// Dispatched instructions are checked against a scoreboard queue.
module tb_rvfpm_issue_ctrl;
    localparam int W = 4;
    localparam int D = 4;

    logic           ck = 1'b0;
    logic           rst;
    logic           enable;
    logic           issue_valid;
    logic           issue_ready;
    logic [31:0]    issue_instr;
    logic [W-1:0]   issue_id;
    logic           commit_valid;
    logic [W-1:0]   commit_id;
    logic           commit_kill;
    logic           fpu_valid;
    logic           fpu_ready;
    logic [31:0]    fpu_instr;
    logic [W-1:0]   fpu_id;
    logic [2:0]     queue_count;
    logic [D*W-1:0] queue_ids;
    logic [D-1:0]   queue_valid;

    rvfpm_issue_ctrl #(.X_ID_WIDTH(W), .QUEUE_DEPTH(D)) dut (
        .ck           (ck),
        .rst          (rst),
        .enable       (enable),
        .issue_valid  (issue_valid),
        .issue_ready  (issue_ready),
        .issue_instr  (issue_instr),
        .issue_id     (issue_id),
        .commit_valid (commit_valid),
        .commit_id    (commit_id),
        .commit_kill  (commit_kill),
        .fpu_valid    (fpu_valid),
        .fpu_ready    (fpu_ready),
        .fpu_instr    (fpu_instr),
        .fpu_id       (fpu_id),
        .queue_count  (queue_count),
        .queue_ids    (queue_ids),
        .queue_valid  (queue_valid)
    );

    always #5 ck = ~ck;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [W-1:0] id;
        logic [31:0]  instr;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    typedef struct {
        logic         iv;
        logic [W-1:0] iid;
        logic [31:0]  instr;
        logic         cv;
        logic [W-1:0] cid;
        logic         kill;
        logic         fr;
        logic         en;
        logic         e_ir;
        logic         e_fv;
        logic [W-1:0] e_fid;
        logic [2:0]   e_cnt;
        logic [D-1:0] e_qv;
    } vec_t;
    vec_t vt[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [W-1:0] iid, input logic [31:0] instr,
                         input logic cv, input logic [W-1:0] cid, input logic kill,
                         input logic fr, input logic en);
        issue_valid  = iv;
        issue_id     = iid;
        issue_instr  = instr;
        commit_valid = cv;
        commit_id    = cid;
        commit_kill  = kill;
        fpu_ready    = fr;
        enable       = en;
    endtask

    task automatic idle(input logic fr);
        drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0, fr, 1'b1);
    endtask

    task automatic sb_push(input logic [W-1:0] id, input logic [31:0] instr);
        exp_t e;
        e.id    = id;
        e.instr = instr;
        sb.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge ck);
        #1;
    endtask

    // Scoreboard side: every accepted dispatch must match the oldest expectation.
    always @(negedge ck) begin
        if (fpu_valid === 1'b1 && fpu_ready === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL dispatch_unexpected: got id %0d want none", fpu_id);
            end else begin
                mon_e = sb.pop_front();
                chk("dispatch_id", 32'(fpu_id), 32'(mon_e.id));
                chk("dispatch_instr", fpu_instr, mon_e.instr);
                $display("dispatch id=%0d instr=%h", fpu_id, fpu_instr);
            end
        end
    end

    initial begin
        bit dup_accept;
`ifdef RVFPM_DUP_ID_CHECK_EN
        dup_accept = 1'b0;
`else
        dup_accept = 1'b1;
`endif
        //            iv    iid    instr          cv    cid    kill  fr    en    e_ir  e_fv  e_fid  e_cnt e_qv
        vt[0]  = '{1'b1, 4'd3, 32'h00A5_F053, 1'b1, 4'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 3'd0, 4'b0000};
        vt[1]  = '{1'b0, 4'd0, 32'h0,         1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd3, 3'd1, 4'b0001};
        vt[2]  = '{1'b0, 4'd0, 32'h0,         1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 3'd0, 4'b0000};
        vt[3]  = '{1'b1, 4'd0, 32'h1000_0000, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 3'd0, 4'b0000};
        vt[4]  = '{1'b1, 4'd1, 32'h1000_0001, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 3'd1, 4'b0001};
        vt[5]  = '{1'b1, 4'd2, 32'h1000_0002, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 3'd2, 4'b0011};
        vt[6]  = '{1'b1, 4'd3, 32'h1000_0003, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 3'd3, 4'b0111};
        vt[7]  = '{1'b1, 4'd4, 32'h1000_0004, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 3'd4, 4'b1111};
        vt[8]  = '{1'b0, 4'd0, 32'h0,         1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 3'd4, 4'b1111};
        vt[9]  = '{1'b1, 4'd4, 32'h1000_0004, 1'b1, 4'd1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd1, 3'd3, 4'b0111};
        vt[10] = '{1'b0, 4'd0, 32'h0,         1'b1, 4'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd1, 3'd4, 4'b1111};
        vt[11] = '{1'b0, 4'd0, 32'h0,         1'b1, 4'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd2, 3'd3, 4'b0111};
        vt[12] = '{1'b0, 4'd0, 32'h0,         1'b1, 4'd4, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd3, 3'd2, 4'b0011};
        vt[13] = '{1'b0, 4'd0, 32'h0,         1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd4, 3'd1, 4'b0001};
        vt[14] = '{1'b0, 4'd0, 32'h0,         1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 3'd0, 4'b0000};

        // Power-on reset.
        rst = 1'b1;
        idle(1'b1);
        next_cycle();
        #3;
        chk("rst_issue_ready", 32'(issue_ready), 32'd0);
        chk("rst_fpu_valid", 32'(fpu_valid), 32'd0);
        next_cycle();
        rst = 1'b0;
        #3;
        chk("init_count", 32'(queue_count), 32'd0);
        chk("init_qvalid", 32'(queue_valid), 32'd0);
        chk("init_qids", 32'(queue_ids), 32'd0);
        chk("init_fpu_id", 32'(fpu_id), 32'd0);
        chk("init_fpu_instr", fpu_instr, 32'd0);
        next_cycle();

        // Mid-traffic reset with three uncommitted entries queued.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, W'(7 + i), 32'h7000_0000 + 32'(i), 1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
            next_cycle();
        end
        idle(1'b1);
        #3;
        chk("prerst_count", 32'(queue_count), 32'd3);
        chk("prerst_qids", 32'(queue_ids), 32'h0000_0987);
        next_cycle();
        rst = 1'b1;
        drive(1'b1, 4'd10, 32'hDEAD_0000, 1'b1, 4'd7, 1'b0, 1'b1, 1'b1);
        #3;
        chk("midrst_issue_ready", 32'(issue_ready), 32'd0);
        next_cycle();
        next_cycle();
        rst = 1'b0;
        idle(1'b1);
        #3;
        chk("postrst_count", 32'(queue_count), 32'd0);
        chk("postrst_fpu_valid", 32'(fpu_valid), 32'd0);
        chk("postrst_qvalid", 32'(queue_valid), 32'd0);
        next_cycle();

        // Table: basic flow, fill to full, refill with tail wrap, back-to-back dispatch.
        for (int i = 0; i < 15; i++) begin
            drive(vt[i].iv, vt[i].iid, vt[i].instr, vt[i].cv, vt[i].cid, vt[i].kill, vt[i].fr, vt[i].en);
            if (vt[i].iv && vt[i].e_ir) sb_push(vt[i].iid, vt[i].instr);
            #3;
            chk($sformatf("row%0d_issue_ready", i), 32'(issue_ready), 32'(vt[i].e_ir));
            chk($sformatf("row%0d_fpu_valid", i), 32'(fpu_valid), 32'(vt[i].e_fv));
            chk($sformatf("row%0d_fpu_id", i), 32'(fpu_id), 32'(vt[i].e_fid));
            chk($sformatf("row%0d_count", i), 32'(queue_count), 32'(vt[i].e_cnt));
            chk($sformatf("row%0d_qvalid", i), 32'(queue_valid), 32'(vt[i].e_qv));
            next_cycle();
        end

        // Kill at head: entry 1 dropped silently, entry 2 dispatched after it.
        drive(1'b1, 4'd1, 32'h0011_0000, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
        next_cycle();
        drive(1'b1, 4'd2, 32'h0022_0000, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
        sb_push(4'd2, 32'h0022_0000);
        next_cycle();
        drive(1'b0, 4'd0, 32'h0, 1'b1, 4'd1, 1'b1, 1'b1, 1'b1);
        #3;
        chk("kill_pre_count", 32'(queue_count), 32'd2);
        next_cycle();
        drive(1'b0, 4'd0, 32'h0, 1'b1, 4'd2, 1'b0, 1'b1, 1'b1);
        #3;
        chk("kill_head_fpu_valid", 32'(fpu_valid), 32'd0);
        chk("kill_head_count", 32'(queue_count), 32'd2);
        next_cycle();
        idle(1'b1);
        #3;
        chk("kill_next_fpu_valid", 32'(fpu_valid), 32'd1);
        chk("kill_next_fpu_id", 32'(fpu_id), 32'd2);
        chk("kill_next_count", 32'(queue_count), 32'd1);
        next_cycle();
        #3;
        chk("kill_drained_count", 32'(queue_count), 32'd0);

        // Backpressure then enable low.
        drive(1'b1, 4'd6, 32'h0066_F053, 1'b1, 4'd6, 1'b0, 1'b0, 1'b1);
        sb_push(4'd6, 32'h0066_F053);
        next_cycle();
        for (int k = 0; k < 3; k++) begin
            idle(1'b0);
            #3;
            chk($sformatf("bp%0d_fpu_valid", k), 32'(fpu_valid), 32'd1);
            chk($sformatf("bp%0d_fpu_id", k), 32'(fpu_id), 32'd6);
            chk($sformatf("bp%0d_fpu_instr", k), fpu_instr, 32'h0066_F053);
            next_cycle();
        end
        drive(1'b1, 4'd9, 32'h0099_0000, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        #3;
        chk("dis_fpu_valid", 32'(fpu_valid), 32'd0);
        chk("dis_issue_ready", 32'(issue_ready), 32'd0);
        next_cycle();
        idle(1'b1);
        #3;
        chk("dis_hold_count", 32'(queue_count), 32'd1);
        chk("reen_fpu_valid", 32'(fpu_valid), 32'd1);
        next_cycle();
        #3;
        chk("bp_drained_count", 32'(queue_count), 32'd0);
        next_cycle();

        // Duplicate ID 5.
        drive(1'b1, 4'd5, 32'h0055_0001, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
        sb_push(4'd5, 32'h0055_0001);
        next_cycle();
        drive(1'b1, 4'd5, 32'h0055_0002, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
        if (dup_accept) sb_push(4'd5, 32'h0055_0002);
        #3;
        chk("dup_issue_ready", 32'(issue_ready), 32'(dup_accept));
        next_cycle();
        drive(1'b0, 4'd0, 32'h0, 1'b1, 4'd5, 1'b0, 1'b1, 1'b1);
        #3;
        chk("dup_count", 32'(queue_count), dup_accept ? 32'd2 : 32'd1);
        next_cycle();
        idle(1'b1);
        for (int k = 0; k < (dup_accept ? 2 : 1); k++) begin
            #3;
            chk($sformatf("dup%0d_fpu_valid", k), 32'(fpu_valid), 32'd1);
            chk($sformatf("dup%0d_fpu_id", k), 32'(fpu_id), 32'd5);
            next_cycle();
        end
        #3;
        chk("dup_drained_count", 32'(queue_count), 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
